// File: rtl/prbs7_tx_gen_if.sv
// Control and data bundle for the PRBS7 word source.
// master = the block driving controls and consuming the stream; slave = the generator.
interface prbs7_tx_gen_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic [1:0]       mode;
  logic             slip_req;
  logic             inj_single;
  logic [4:0]       inj_bit;
  logic [15:0]      inj_period;
  logic [31:0]      dout;
  logic             dout_valid;
  logic [4:0]       slip_offset;
  logic [CNT_W-1:0] word_count;
  logic [15:0]      inj_count;

  modport master (
    output enable, mode, slip_req, inj_single, inj_bit, inj_period,
    input  dout, dout_valid, slip_offset, word_count, inj_count
  );

  modport slave (
    input  enable, mode, slip_req, inj_single, inj_bit, inj_period,
    output dout, dout_valid, slip_offset, word_count, inj_count
  );
endinterface

// File: rtl/prbs7_tx_gen.sv
// PRBS7 (x^7+x^6+1) 32-bit/cycle word source with test patterns, bit slip and error injection.
// Error injection is built only when PRBS_TX_ERR_INJ_EN is defined.
module prbs7_tx_gen #(
  parameter logic [6:0] SEED  = 7'h7F,
  parameter int         CNT_W = 32
) (
  input logic           clk,
  input logic           reset,
  prbs7_tx_gen_if.slave bus
);
  localparam int         DATA_W   = 32;
  localparam logic [6:0] SEED_EFF = (SEED == 7'h00) ? 7'h7F : SEED;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t              state, state_n;
  logic                advance, emit;
  logic                primed;
  logic [6:0]          lfsr_p0;
  logic [DATA_W-1:0]   gen_cur_p1, gen_prev_p1;
  logic [DATA_W-1:0]   dout_p2;
  logic                vld_p2;
  logic [4:0]          slip_offset;
  logic [CNT_W-1:0]    word_count;
  logic [DATA_W-1:0]   inj_mask;
  logic [15:0]         inj_count;

  function automatic logic [DATA_W+6:0] prbs_step(input logic [6:0] st_in);
    logic [6:0]        st;
    logic [DATA_W-1:0] w;
    logic              nb;
    st = st_in;
    w  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      nb   = st[6] ^ st[5];
      w[i] = nb;
      st   = {st[5:0], nb};
    end
    return {st, w};
  endfunction

  function automatic logic [DATA_W-1:0] apply_mode(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] w);
    case (m)
      2'b00:   return w;
      2'b01:   return '0;
      2'b10:   return 32'h5555_5555;
      default: return ~w;
    endcase
  endfunction

  logic [DATA_W+6:0]   step;
  logic [2*DATA_W-1:0] buf_w, buf_sh;
  logic [DATA_W-1:0]   sel;

  assign step   = prbs_step(lfsr_p0);
  assign buf_w  = {gen_cur_p1, gen_prev_p1};
  assign buf_sh = buf_w >> (7'd32 - {2'b00, slip_offset});
  assign sel    = buf_sh[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // The refill only advances once per reset so a stall/resume keeps the stream contiguous.
  always_comb begin
    state_n = state;
    advance = 1'b0;
    emit    = 1'b0;
    case (state)
      IDLE: if (bus.enable) state_n = FILL;
      FILL: begin
        if (bus.enable) begin
          state_n = RUN;
          advance = !primed;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (bus.enable) begin
          emit    = 1'b1;
          advance = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage 1: word generation
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_p0     <= SEED_EFF;
      gen_cur_p1  <= '0;
      gen_prev_p1 <= '0;
      primed      <= 1'b0;
    end else if (advance) begin
      lfsr_p0     <= step[DATA_W+6:DATA_W];
      gen_prev_p1 <= gen_cur_p1;
      gen_cur_p1  <= apply_mode(bus.mode, step[DATA_W-1:0]);
      primed      <= 1'b1;
    end
  end

  // Stage 2: slip select and injection
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_p2    <= '0;
      vld_p2     <= 1'b0;
      word_count <= '0;
    end else begin
      vld_p2 <= emit;
      if (emit) begin
        dout_p2    <= sel ^ inj_mask;
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                        slip_offset <= '0;
    else if (bus.enable && bus.slip_req) slip_offset <= slip_offset + 5'd1;
  end

`ifdef PRBS_TX_ERR_INJ_EN
  logic        inj_pend;
  logic [15:0] per_cnt, per_last;
  logic        per_hit, inj_req;

  always_comb begin
    per_hit  = (bus.inj_period != 16'd0) && (bus.inj_period == per_last) &&
               (per_cnt == bus.inj_period - 16'd1);
    inj_req  = emit && (per_hit || inj_pend || bus.inj_single);
    inj_mask = inj_req ? (32'd1 << bus.inj_bit) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_pend  <= 1'b0;
      per_cnt   <= '0;
      per_last  <= '0;
      inj_count <= '0;
    end else begin
      per_last <= bus.inj_period;
      if (bus.inj_period != per_last || bus.inj_period == 16'd0) per_cnt <= '0;
      else if (emit) per_cnt <= per_hit ? 16'd0 : per_cnt + 16'd1;
      if (emit)                inj_pend <= 1'b0;
      else if (bus.inj_single) inj_pend <= 1'b1;
      if (inj_req && inj_count != 16'hFFFF) inj_count <= inj_count + 16'd1;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = ^{bus.inj_single, bus.inj_bit, bus.inj_period};
  assign inj_mask   = '0;
  assign inj_count  = '0;
`endif

  assign bus.dout        = dout_p2;
  assign bus.dout_valid  = vld_p2;
  assign bus.slip_offset = slip_offset;
  assign bus.word_count  = word_count;
  assign bus.inj_count   = inj_count;
endmodule
